// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status strobes out
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
  modport master (output rx, input data_out, valid, frame_err, busy);
  modport slave  (input rx, output data_out, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling; define UART_RX_MAJORITY_EN for 2-of-3 glitch filtering
module uart_rx #(
  parameter int CLK_PER_BIT = 16
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;
  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d, data_q, data_d;
  logic            valid_q, valid_d, ferr_q, ferr_d;
  logic            rx_s, sample;
  assign rx_s = sync_q[1];
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  logic [2:0] hist;
  assign hist   = {hist_q, rx_s};
  assign sample = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  // the two previous synchronised values complete the three-sample window
  always_ff @(posedge clk or posedge rst)
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist[1:0];
`else
  assign sample = rx_s;
`endif
  // synchroniser, frame state and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  // next state: count to mid-bit, sample, and advance; counter clears on every state change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = sample ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d   = '0;
        shift_d = {sample, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == FULL) begin
        cnt_d   = '0;
        data_d  = sample ? shift_q : data_q;
        valid_d = sample;
        ferr_d  = !sample;
        state_d = sample ? IDLE : RECOVER;
      end
      RECOVER: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : RECOVER;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a line-level sampling model
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int FL  = 10 * CPB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_rx_if bus();
  uart_rx #(.CLK_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_both   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       line_q[FL];
  always @(negedge clk) begin
    if (bus.valid) begin
      got_q.push_back(bus.data_out);
      n_valid++;
    end
    if (bus.frame_err) n_ferr++;
    if (bus.valid && bus.frame_err) n_both++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic samp(input int j);
`ifdef UART_RX_MAJORITY_EN
    return (int'(line_q[j]) + int'(line_q[j-1]) + int'(line_q[j-2])) >= 2;
`else
    return line_q[j];
`endif
  endfunction
  function automatic logic [7:0] decode();
    logic [7:0] d;
    for (int b = 0; b < 8; b++) d[b] = samp(CPB * (b + 1) + CPB / 2);
    return d;
  endfunction
  task automatic idle(input int n);
    repeat (n) @(negedge clk) bus.rx = 1'b1;
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int glitch, input int len);
    for (int j = 0; j < FL; j++) begin
      int b;
      b = j / CPB;
      line_q[j] = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
      if (j == glitch) line_q[j] = ~line_q[j];
    end
    for (int j = 0; j < len; j++) @(negedge clk) bus.rx = line_q[j];
    if (len == FL && samp(9 * CPB + CPB / 2)) exp_q.push_back(decode());
  endtask
  task automatic compare(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int v0, f0;
    bus.rx = 1'b1;
    #1;
    check("rst_data", bus.data_out, 8'h00);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_ferr", bus.frame_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);
    send(8'hA5, 1'b1, -1, FL);
    idle(20);
    check("a5_valid_n", n_valid, 1);
    check("a5_data", bus.data_out, 8'hA5);
    check("a5_ferr_n", n_ferr, 0);
    check("a5_busy", bus.busy, 1'b0);
    compare("a5");
    send(8'h00, 1'b1, -1, FL);
    send(8'hFF, 1'b1, -1, FL);
    idle(20);
    check("b2b_valid_n", n_valid, 3);
    compare("b2b");
    v0 = n_valid;
    f0 = n_ferr;
    repeat (4) @(negedge clk) bus.rx = 1'b0;
    idle(CPB / 2 + 3);
    check("glitch_busy", bus.busy, 1'b0);
    idle(2 * CPB);
    check("glitch_valid_n", n_valid, v0);
    check("glitch_ferr_n", n_ferr, f0);
    send(8'h11, 1'b1, -1, FL);
    idle(20);
    compare("pre11");
    v0 = n_valid;
    send(8'h3C, 1'b0, -1, FL);
    repeat (3 * CPB) @(negedge clk) bus.rx = 1'b0;
    check("ferr_n", n_ferr, f0 + 1);
    check("ferr_valid_n", n_valid, v0);
    check("ferr_data", bus.data_out, 8'h11);
    check("ferr_busy_low_line", bus.busy, 1'b1);
    idle(5);
    check("ferr_busy_recover", bus.busy, 1'b0);
    check("ferr_n_after", n_ferr, f0 + 1);
    compare("ferr");
    v0 = n_valid;
    f0 = n_ferr;
    send(8'h5A, 1'b1, -1, 5 * CPB + 4);
    @(negedge clk) rst = 1'b1;
    #1;
    check("abort_data", bus.data_out, 8'h00);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_valid", bus.valid, 1'b0);
    check("abort_ferr", bus.frame_err, 1'b0);
    idle(3);
    @(negedge clk) rst = 1'b0;
    idle(5);
    check("abort_valid_n", n_valid, v0);
    check("abort_ferr_n", n_ferr, f0);
    send(8'hC3, 1'b1, -1, FL);
    idle(20);
    check("c3_data", bus.data_out, 8'hC3);
    compare("c3");
    send(8'h81, 1'b1, CPB + CPB / 2, FL);
    idle(20);
`ifdef UART_RX_MAJORITY_EN
    check("maj_data", bus.data_out, 8'h81);
`else
    check("maj_data", bus.data_out, 8'h80);
`endif
    compare("maj");
    f0 = n_ferr;
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), 1'b1, -1, FL);
      idle($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 40));
    end
    idle(20);
    check("rand_ferr_n", n_ferr, f0);
    check("rand_busy", bus.busy, 1'b0);
    compare("rand");
    check("never_both", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
